// File: rtl/mem_arbiter_pkg.sv
// Shared widths, requester IDs and FSM encoding for the I$/D$ memory-port arbiter.
`timescale 1ns/1ps
package mem_arbiter_pkg;

   localparam int MEM_ADDR_BITS = 28;
   localparam int MEM_DATA_BITS = 128;
   localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

   localparam logic MEM_REQ_ID_IC = 1'b0;
   localparam logic MEM_REQ_ID_DC = 1'b1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WDATA = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order owner-tag FIFO for outstanding reads; 1 bit wide, power-of-2 depth.
`timescale 1ns/1ps
module mem_arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        tag_mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign do_push = push & (~full | do_pop);
   assign dout    = tag_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) tag_mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I$ and D$. MEM_ARB_RR_EN selects round-robin (else D$ fixed
// priority); MEM_ARB_SIM_CHECKS enables a simulation $error on responses with no read outstanding.
`timescale 1ns/1ps
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ic_mem_req_valid,
   output logic                     ic_mem_req_ready,
   input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
   input  logic                     ic_mem_req_rw,
   input  logic                     ic_mem_req_data_valid,
   output logic                     ic_mem_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0] ic_mem_req_data_bits,
   input  logic [MEM_MASK_BITS-1:0] ic_mem_req_data_mask,
   output logic                     ic_mem_resp_valid,
   output logic [MEM_DATA_BITS-1:0] ic_mem_resp_data,
   input  logic                     dc_mem_req_valid,
   output logic                     dc_mem_req_ready,
   input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
   input  logic                     dc_mem_req_rw,
   input  logic                     dc_mem_req_data_valid,
   output logic                     dc_mem_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0] dc_mem_req_data_bits,
   input  logic [MEM_MASK_BITS-1:0] dc_mem_req_data_mask,
   output logic                     dc_mem_resp_valid,
   output logic [MEM_DATA_BITS-1:0] dc_mem_resp_data,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
   output logic                     mem_req_rw,
   output logic                     mem_req_data_valid,
   input  logic                     mem_req_data_ready,
   output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
   output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
   input  logic                     mem_resp_valid,
   input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

   arb_state_e state;
   arb_state_e state_nxt;
   logic       owner;
   logic       win;
   logic       sel;
   logic       any_valid;
   logic       blocked;
   logic       addr_fire;
   logic       data_fire;
   logic       resp_hit;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;
   logic       fifo_push;

   assign any_valid = ic_mem_req_valid | dc_mem_req_valid;
   assign resp_hit  = mem_resp_valid & ~fifo_empty & ~reset;
   // A full tag FIFO only blocks when no response frees a slot this cycle.
   assign blocked   = fifo_full & ~resp_hit;
   assign addr_fire = mem_req_valid & mem_req_ready;
   assign data_fire = mem_req_data_valid & mem_req_data_ready;
   assign sel       = (state == S_WDATA) ? owner : win;
   assign fifo_push = addr_fire & ~mem_req_rw;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr;

   always_comb begin
      if (ic_mem_req_valid && dc_mem_req_valid) win = rr_ptr;
      else                                      win = dc_mem_req_valid ? MEM_REQ_ID_DC : MEM_REQ_ID_IC;
   end

   always_ff @(posedge clk) begin
      if (reset)          rr_ptr <= MEM_REQ_ID_IC;
      else if (addr_fire) rr_ptr <= ~win;
   end
`else
   assign win = dc_mem_req_valid ? MEM_REQ_ID_DC : MEM_REQ_ID_IC;
`endif

   always_comb begin
      mem_req_valid         = 1'b0;
      mem_req_addr          = '0;
      mem_req_rw            = 1'b0;
      mem_req_data_valid    = 1'b0;
      mem_req_data_bits     = '0;
      mem_req_data_mask     = '0;
      ic_mem_req_ready      = 1'b0;
      dc_mem_req_ready      = 1'b0;
      ic_mem_req_data_ready = 1'b0;
      dc_mem_req_data_ready = 1'b0;
      if (!reset) begin
         if (state == S_IDLE && any_valid && !blocked) begin
            mem_req_valid    = 1'b1;
            mem_req_addr     = sel ? dc_mem_req_addr : ic_mem_req_addr;
            mem_req_rw       = sel ? dc_mem_req_rw : ic_mem_req_rw;
            ic_mem_req_ready = (sel == MEM_REQ_ID_IC) & mem_req_ready;
            dc_mem_req_ready = (sel == MEM_REQ_ID_DC) & mem_req_ready;
         end
         // Write-data channel follows the issuing writer in IDLE, the locked owner in WDATA.
         if (state == S_WDATA || (mem_req_valid && mem_req_rw)) begin
            mem_req_data_valid    = sel ? dc_mem_req_data_valid : ic_mem_req_data_valid;
            mem_req_data_bits     = sel ? dc_mem_req_data_bits : ic_mem_req_data_bits;
            mem_req_data_mask     = sel ? dc_mem_req_data_mask : ic_mem_req_data_mask;
            ic_mem_req_data_ready = (sel == MEM_REQ_ID_IC) & mem_req_data_ready;
            dc_mem_req_data_ready = (sel == MEM_REQ_ID_DC) & mem_req_data_ready;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (addr_fire && mem_req_rw && !data_fire) state_nxt = S_WDATA;
         S_WDATA: if (data_fire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         owner <= MEM_REQ_ID_IC;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && state_nxt == S_WDATA) owner <= win;
      end
   end

   mem_arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (resp_hit),
      .din   (sel),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ic_mem_resp_valid = resp_hit & (fifo_head == MEM_REQ_ID_IC);
   assign dc_mem_resp_valid = resp_hit & (fifo_head == MEM_REQ_ID_DC);
   assign ic_mem_resp_data  = mem_resp_data;
   assign dc_mem_resp_data  = mem_resp_data;

`ifdef MEM_ARB_SIM_CHECKS
   always_ff @(posedge clk) begin
      if (!reset && mem_resp_valid && fifo_empty)
         $error("mem_arbiter: read response with no read outstanding, dropped");
   end
`endif

endmodule
